switch_allocator: RTL and testbench

Per-output round-robin switch allocator with packet locking for the mesh router. It sits between the input units, which present head/body/tail flits and a computed output port, and the crossbar plus output units. Each cycle it decides which input drives each output. Once a head flit wins an output, that output stays locked to the same input until the tail flit passes, so wormhole packets are never interleaved.

---
 rtl/switch_allocator_pkg.sv | 22 ++
 rtl/switch_allocator_if.sv | 30 +++
 rtl/switch_allocator_rr_arbiter.sv | 33 +++
 rtl/switch_allocator.sv | 119 +++++++++++
 tb/tb_switch_allocator.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared types for the mesh-router switch allocator.
// Holds the default port count, the port-index type, the allocator state encoding
// and a wrap-around increment helper used by the round-robin pointers.
package switch_allocator_pkg;

  localparam int NUM_OF_PORTS = 5;
  localparam int PORT_W       = $clog2(NUM_OF_PORTS);

  typedef logic [PORT_W-1:0] port_idx_t;

  // Per-output allocator state, exported so output units and debug logic can decode it.
  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_e;

  // Round-robin successor: idx+1, wrapping from n-1 back to 0.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input units and the switch allocator.
// Combinational: grant-side signals respond to request-side signals in the same cycle.
// Backpressure: i_out_ready gates grants per output; ungranted requests stay pending.
// master: drives i_req/i_req_port/i_head/i_tail/i_out_ready, observes o_* results.
// slave : the allocator, consumes the i_* signals and drives o_grant/o_xbar_sel/o_xbar_valid/o_busy.
interface switch_allocator_if #(
  parameter int NUM_OF_PORTS = switch_allocator_pkg::NUM_OF_PORTS
);
  localparam int PORT_W = $clog2(NUM_OF_PORTS);

  logic [NUM_OF_PORTS-1:0]        i_req;
  logic [NUM_OF_PORTS*PORT_W-1:0] i_req_port;
  logic [NUM_OF_PORTS-1:0]        i_head;
  logic [NUM_OF_PORTS-1:0]        i_tail;
  logic [NUM_OF_PORTS-1:0]        i_out_ready;
  logic [NUM_OF_PORTS-1:0]        o_grant;
  logic [NUM_OF_PORTS*PORT_W-1:0] o_xbar_sel;
  logic [NUM_OF_PORTS-1:0]        o_xbar_valid;
  logic [NUM_OF_PORTS-1:0]        o_busy;

  modport master (
    output i_req, i_req_port, i_head, i_tail, i_out_ready,
    input  o_grant, o_xbar_sel, o_xbar_valid, o_busy
  );

  modport slave (
    input  i_req, i_req_port, i_head, i_tail, i_out_ready,
    output o_grant, o_xbar_sel, o_xbar_valid, o_busy
  );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin N-way arbiter: first set request at or above ptr_i, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is taken.
// Ports: req_i (request vector), ptr_i (search start) -> gnt_o (one-hot), idx_o (winner), any_o.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole packet locking.
// Latency: grants/xbar select are combinational from requests; lock state updates on the next clk edge.
// Backpressure: i_out_ready[j]=0 suppresses output j's grant and freezes its state, owner and pointer.
// Ports: clk, reset (async, active-high), sa (slave side of switch_allocator_if).
module switch_allocator #(
  parameter int NUM_OF_PORTS = switch_allocator_pkg::NUM_OF_PORTS
) (
  input logic                clk,
  input logic                reset,
  switch_allocator_if.slave  sa
);
  import switch_allocator_pkg::*;

  localparam int N  = NUM_OF_PORTS;
  localparam int PW = $clog2(NUM_OF_PORTS);

  logic [N-1:0]  gnt_m  [N];
  logic [PW-1:0] sel_m  [N];
  logic          vld_m  [N];
  logic          busy_m [N];

  for (genvar j = 0; j < N; j++) begin : g_out
    logic [N-1:0]  cand, head_req, arb_gnt, gnt;
    logic [PW-1:0] arb_idx, owner_q, owner_d, rr_q, rr_d, sel;
    logic          arb_any, vld;
    sa_state_e     state_q, state_d;

    // An out-of-range requested port never equals j, so it is silently never granted.
    always_comb begin
      cand = '0;
      for (int i = 0; i < N; i++) begin
        cand[i] = sa.i_req[i] && (sa.i_req_port[i*PW +: PW] == PW'(j));
      end
    end

    // Only head flits may open a new packet on an idle output.
    assign head_req = cand & sa.i_head;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
      .req_i (head_req),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
    );

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      gnt     = '0;
      sel     = '0;
      vld     = 1'b0;
      unique case (state_q)
        SA_IDLE: begin
          if (arb_any && sa.i_out_ready[j]) begin
            gnt  = arb_gnt;
            sel  = arb_idx;
            vld  = 1'b1;
            rr_d = PW'(rr_wrap_inc(int'(arb_idx), N));
            // A head+tail flit completes in one cycle and never locks the output.
            if (!sa.i_tail[arb_idx]) begin
              state_d = SA_LOCKED;
              owner_d = arb_idx;
            end
          end
        end
        SA_LOCKED: begin
          sel = owner_q;
          // Owner's flits pass regardless of the head bit; everyone else waits.
          if (cand[owner_q] && sa.i_out_ready[j]) begin
            gnt[owner_q] = 1'b1;
            vld          = 1'b1;
            if (sa.i_tail[owner_q]) state_d = SA_IDLE;
          end
        end
        default: state_d = SA_IDLE;
      endcase
      // Keep the crossbar quiet while reset is held, even if inputs are still requesting.
      if (reset) begin
        gnt = '0;
        sel = '0;
        vld = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= SA_IDLE;
        owner_q <= '0;
        rr_q    <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        rr_q    <= rr_d;
      end
    end

    assign gnt_m[j]  = gnt;
    assign sel_m[j]  = sel;
    assign vld_m[j]  = vld;
    assign busy_m[j] = (state_q == SA_LOCKED);
  end

  // Each input names a single output, so OR-ing per-output grants never double-grants an input.
  always_comb begin
    sa.o_grant      = '0;
    sa.o_xbar_sel   = '0;
    sa.o_xbar_valid = '0;
    sa.o_busy       = '0;
    for (int j = 0; j < N; j++) begin
      sa.o_grant                 = sa.o_grant | gnt_m[j];
      sa.o_xbar_sel[j*PW +: PW]  = sel_m[j];
      sa.o_xbar_valid[j]         = vld_m[j];
      sa.o_busy[j]               = busy_m[j];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed testbench for switch_allocator with an expected-result queue.
// Each step drives inputs after a rising edge, queues the expected outputs,
// and compares them at the following falling edge.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  localparam int N  = 5;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  switch_allocator_if #(.NUM_OF_PORTS(N)) sa ();

  switch_allocator #(.NUM_OF_PORTS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .sa    (sa)
  );

  typedef struct packed {
    logic [N-1:0]    grant;
    logic [N*PW-1:0] sel;
    logic [N-1:0]    valid;
    logic [N-1:0]    busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [N*PW-1:0] sel1(input int j, input int v);
    logic [N*PW-1:0] s;
    s = '0;
    s[j*PW +: PW] = PW'(v);
    return s;
  endfunction

  task automatic clear_inputs();
    sa.i_req       = '0;
    sa.i_req_port  = '0;
    sa.i_head      = '0;
    sa.i_tail      = '0;
    sa.i_out_ready = '1;
  endtask

  task automatic drive(input int i, input int port, input bit head, input bit tail);
    sa.i_req[i]                = 1'b1;
    sa.i_req_port[i*PW +: PW]  = PW'(port);
    sa.i_head[i]               = head;
    sa.i_tail[i]               = tail;
  endtask

  // Pops the oldest expectation at the falling edge, then advances to just after the next rising edge.
  task automatic check(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      checks++;
      assert (sa.o_grant === e.grant) else begin
        errors++;
        $error("FAIL %s grant: observed %b expected %b", tag, sa.o_grant, e.grant);
      end
      checks++;
      assert (sa.o_xbar_sel === e.sel) else begin
        errors++;
        $error("FAIL %s xbar_sel: observed %h expected %h", tag, sa.o_xbar_sel, e.sel);
      end
      checks++;
      assert (sa.o_xbar_valid === e.valid) else begin
        errors++;
        $error("FAIL %s xbar_valid: observed %b expected %b", tag, sa.o_xbar_valid, e.valid);
      end
      checks++;
      assert (sa.o_busy === e.busy) else begin
        errors++;
        $error("FAIL %s busy: observed %b expected %b", tag, sa.o_busy, e.busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [N-1:0] g, input logic [N*PW-1:0] s,
                      input logic [N-1:0] v, input logic [N-1:0] b);
    exp_t e;
    e.grant = g;
    e.sel   = s;
    e.valid = v;
    e.busy  = b;
    sb_q.push_back(e);
    check(tag);
  endtask

  initial begin
    // Reset held with a live request: outputs must stay zero.
    reset = 1'b1;
    clear_inputs();
    drive(2, 4, 1, 1);
    #1;
    step("rst_gate", 5'b00000, '0, 5'b00000, 5'b00000);
    reset = 1'b0;
    clear_inputs();
    step("idle", 5'b00000, '0, 5'b00000, 5'b00000);

    // Output not ready: no grant.
    drive(2, 4, 1, 1);
    sa.i_out_ready[4] = 1'b0;
    step("not_ready", 5'b00000, '0, 5'b00000, 5'b00000);

    // Single-flit packet 2 -> 4.
    clear_inputs();
    drive(2, 4, 1, 1);
    step("single_flit", 5'b00100, sel1(4, 2), 5'b10000, 5'b00000);
    clear_inputs();
    step("single_after", 5'b00000, '0, 5'b00000, 5'b00000);

    // Out-of-range port index is never granted.
    drive(4, 7, 1, 1);
    drive(3, 5, 1, 1);
    step("bad_port", 5'b00000, '0, 5'b00000, 5'b00000);

    // Round-robin rotation on output 0 among inputs 0, 1, 3.
    clear_inputs();
    drive(0, 0, 1, 1);
    drive(1, 0, 1, 1);
    drive(3, 0, 1, 1);
    step("rr0", 5'b00001, sel1(0, 0), 5'b00001, 5'b00000);
    step("rr1", 5'b00010, sel1(0, 1), 5'b00001, 5'b00000);
    step("rr3", 5'b01000, sel1(0, 3), 5'b00001, 5'b00000);
    step("rr0b", 5'b00001, sel1(0, 0), 5'b00001, 5'b00000);
    step("rr1b", 5'b00010, sel1(0, 1), 5'b00001, 5'b00000);

    // 4-flit packet from input 1 to output 2, input 3 contending from cycle 1.
    clear_inputs();
    drive(1, 2, 1, 0);
    step("lock_head", 5'b00010, sel1(2, 1), 5'b00100, 5'b00000);
    clear_inputs();
    drive(1, 2, 0, 0);
    drive(3, 2, 1, 1);
    step("lock_body1", 5'b00010, sel1(2, 1), 5'b00100, 5'b00100);
    step("lock_body2", 5'b00010, sel1(2, 1), 5'b00100, 5'b00100);
    clear_inputs();
    drive(1, 2, 0, 1);
    drive(3, 2, 1, 1);
    step("lock_tail", 5'b00010, sel1(2, 1), 5'b00100, 5'b00100);
    clear_inputs();
    drive(3, 2, 1, 1);
    step("after_tail", 5'b01000, sel1(2, 3), 5'b00100, 5'b00000);
    clear_inputs();
    step("lock_clear", 5'b00000, '0, 5'b00000, 5'b00000);

    // Stall a locked output: pointer for output 2 is now 4.
    drive(3, 2, 1, 0);
    step("stall_head", 5'b01000, sel1(2, 3), 5'b00100, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      drive(3, 2, 0, 0);
      drive(4, 2, 1, 1);
      sa.i_out_ready[2] = 1'b0;
      step("stall", 5'b00000, sel1(2, 3), 5'b00000, 5'b00100);
    end
    clear_inputs();
    drive(3, 2, 0, 0);
    drive(4, 2, 1, 1);
    step("stall_resume", 5'b01000, sel1(2, 3), 5'b00100, 5'b00100);
    clear_inputs();
    drive(3, 2, 0, 1);
    drive(4, 2, 1, 1);
    step("stall_tail", 5'b01000, sel1(2, 3), 5'b00100, 5'b00100);
    clear_inputs();
    drive(4, 2, 1, 1);
    drive(1, 2, 1, 1);
    step("ptr_held", 5'b10000, sel1(2, 4), 5'b00100, 5'b00000);
    clear_inputs();
    drive(1, 2, 1, 1);
    step("ptr_next", 5'b00010, sel1(2, 1), 5'b00100, 5'b00000);

    // Reset while output 2 is locked.
    clear_inputs();
    drive(1, 2, 1, 0);
    step("rl_head", 5'b00010, sel1(2, 1), 5'b00100, 5'b00000);
    clear_inputs();
    drive(1, 2, 0, 0);
    reset = 1'b1;
    step("rl_reset", 5'b00000, '0, 5'b00000, 5'b00000);
    reset = 1'b0;
    clear_inputs();
    drive(3, 2, 1, 1);
    step("rl_fresh", 5'b01000, sel1(2, 3), 5'b00100, 5'b00000);

    // Two concurrent 5-flit packets: 0 -> 1 and 2 -> 3.
    clear_inputs();
    drive(0, 1, 1, 0);
    drive(2, 3, 1, 0);
    step("dual_head", 5'b00101, sel1(1, 0) | sel1(3, 2), 5'b01010, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      drive(0, 1, 0, 0);
      drive(2, 3, 0, 0);
      step("dual_body", 5'b00101, sel1(1, 0) | sel1(3, 2), 5'b01010, 5'b01010);
    end
    clear_inputs();
    drive(0, 1, 0, 1);
    drive(2, 3, 0, 1);
    step("dual_tail", 5'b00101, sel1(1, 0) | sel1(3, 2), 5'b01010, 5'b01010);
    clear_inputs();
    step("dual_done", 5'b00000, '0, 5'b00000, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
